// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller:
// segment patterns, active-low digit enables, the scan FSM state type and
// the per-digit register entry.
package seg7_pkg;

  // Segment patterns, bit order {G,F,E,D,C,B,A}, active-high
  localparam logic [6:0] NUM_0   = 7'h3F;
  localparam logic [6:0] NUM_1   = 7'h06;
  localparam logic [6:0] NUM_2   = 7'h5B;
  localparam logic [6:0] NUM_3   = 7'h4F;
  localparam logic [6:0] NUM_4   = 7'h66;
  localparam logic [6:0] NUM_5   = 7'h6D;
  localparam logic [6:0] NUM_6   = 7'h7D;
  localparam logic [6:0] NUM_7   = 7'h07;
  localparam logic [6:0] NUM_8   = 7'h7F;
  localparam logic [6:0] NUM_9   = 7'h6F;
  localparam logic [6:0] NUM_A   = 7'h77;
  localparam logic [6:0] NUM_B   = 7'h7C;
  localparam logic [6:0] NUM_C   = 7'h58;
  localparam logic [6:0] NUM_D   = 7'h5E;
  localparam logic [6:0] NUM_E   = 7'h79;
  localparam logic [6:0] NUM_F   = 7'h71;
  localparam logic [6:0] NUM_BLK = 7'b0000000;

  // Digit enables, active-low one-hot
  localparam logic [3:0] EN_1   = 4'b1110;
  localparam logic [3:0] EN_2   = 4'b1101;
  localparam logic [3:0] EN_3   = 4'b1011;
  localparam logic [3:0] EN_4   = 4'b0111;
  localparam logic [3:0] EN_OFF = 4'b1111;

  typedef enum logic [1:0] {SHOW, GUARD, COMMIT} state_t;

  // One digit's display content (shadow and active sets use the same layout)
  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

  // Enable pattern for a digit index, 0 = DS_EN1
  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    case (idx)
      2'd0:    return EN_1;
      2'd1:    return EN_2;
      2'd2:    return EN_3;
      default: return EN_4;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder with blanking; a blanked digit
// drives no segments and no decimal point.
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg,
  output logic       dp
);

  // Map the nibble to its segment pattern unless the digit is blanked
  always_comb begin
    seg = NUM_BLK;
    dp  = 1'b0;
    if (!digit.blank) begin
      dp = digit.dp;
      case (digit.value)
        4'h0: seg = NUM_0;
        4'h1: seg = NUM_1;
        4'h2: seg = NUM_2;
        4'h3: seg = NUM_3;
        4'h4: seg = NUM_4;
        4'h5: seg = NUM_5;
        4'h6: seg = NUM_6;
        4'h7: seg = NUM_7;
        4'h8: seg = NUM_8;
        4'h9: seg = NUM_9;
        4'hA: seg = NUM_A;
        4'hB: seg = NUM_B;
        4'hC: seg = NUM_C;
        4'hD: seg = NUM_D;
        4'hE: seg = NUM_E;
        default: seg = NUM_F;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-enable 7-segment
// display. Writes land in shadow registers and are copied to the active set
// in a one-cycle COMMIT at the end of every frame. All outputs are registered
// from next-state values, so they line up with the state they describe.
// Optional feature macro: SEG7_SCAN_BRIGHT_EN (adds bright[2:0] dimming).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL_CYC = 12000,
  parameter int GUARD_CYC = 48
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEG7_SCAN_BRIGHT_EN
  input  logic [2:0] bright,
`endif
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [3:0] wr_value,
  input  logic       wr_dp,
  input  logic       wr_blank,
  output logic [6:0] ds_seg,
  output logic       ds_dp,
  output logic [3:0] ds_en,
  output logic       frame_tick
);

  localparam int PHASE_MAX = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
  localparam int PW        = $clog2(PHASE_MAX);
  localparam int TW        = PW + 1;  // wide enough to hold DWELL_CYC itself
  localparam logic [PW-1:0] DWELL_LAST  = PW'(DWELL_CYC - 1);
  localparam logic [PW-1:0] GUARD_LAST  = PW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] THRESH_FULL = TW'(DWELL_CYC);

  state_t        state_reg, state_next;
  logic [1:0]    digit_reg, digit_next;
  logic [PW-1:0] phase_reg, phase_next;

  digit_t        shadow_reg [4];
  digit_t        active_reg [4];
  digit_t        shown;
  logic [3:0]    wr_hit;
  logic          wr_fire;
  logic [6:0]    dec_seg;
  logic          dec_dp;
  logic          lit_next;

  assign wr_fire = wr_valid && wr_ready;

  // Per-digit write strobes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      assign wr_hit[gi] = wr_fire && (wr_digit == 2'(gi));
    end
  endgenerate

  // Scan sequencing: SHOW d -> GUARD -> SHOW d+1 ... GUARD(3) -> COMMIT -> SHOW 0
  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    phase_next = phase_reg + PW'(1);
    case (state_reg)
      SHOW: begin
        if (phase_reg == DWELL_LAST) begin
          state_next = GUARD;
          phase_next = '0;
        end
      end
      GUARD: begin
        if (phase_reg == GUARD_LAST) begin
          phase_next = '0;
          if (digit_reg == 2'd3) begin
            state_next = COMMIT;
          end else begin
            state_next = SHOW;
            digit_next = digit_reg + 2'd1;
          end
        end
      end
      COMMIT: begin
        state_next = SHOW;
        digit_next = 2'd0;
        phase_next = '0;
      end
      default: begin
        state_next = COMMIT;
        digit_next = 2'd3;
        phase_next = '0;
      end
    endcase
  end

`ifdef SEG7_SCAN_BRIGHT_EN
  logic [TW-1:0] thresh_reg, thresh_next;

  // Brightness threshold is only re-sampled in COMMIT so a frame is uniform
  always_comb begin
    thresh_next = thresh_reg;
    if (state_reg == COMMIT)
      thresh_next = TW'(((int'(bright) + 1) * DWELL_CYC) >> 3);
    lit_next = ({1'b0, phase_next} < thresh_next);
  end

  // Hold the per-frame brightness threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) thresh_reg <= THRESH_FULL;
    else     thresh_reg <= thresh_next;
  end
`else
  // Without dimming the digit is lit for its whole dwell
  always_comb begin
    lit_next = ({1'b0, phase_next} < THRESH_FULL);
  end
`endif

  // Shadow captures accepted writes; active is refreshed from shadow in COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        shadow_reg[i] <= DIGIT_RESET;
        active_reg[i] <= DIGIT_RESET;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_hit[i])
          shadow_reg[i] <= '{value: wr_value, dp: wr_dp, blank: wr_blank};
        if (state_reg == COMMIT)
          active_reg[i] <= shadow_reg[i];
      end
    end
  end

  // Leaving COMMIT, active is being loaded from shadow on this same edge, so
  // the first SHOW of the new frame must already decode the shadow entry.
  assign shown = (state_reg == COMMIT) ? shadow_reg[digit_next] : active_reg[digit_next];

  seg7_decode u_decode (
    .digit (shown),
    .seg   (dec_seg),
    .dp    (dec_dp)
  );

  // FSM state plus registered outputs computed for the state being entered.
  // Reset parks in the last GUARD cycle of digit 3 so the first clock commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= GUARD;
      digit_reg  <= 2'd3;
      phase_reg  <= GUARD_LAST;
      ds_en      <= EN_OFF;
      ds_seg     <= NUM_BLK;
      ds_dp      <= 1'b0;
      frame_tick <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      digit_reg  <= digit_next;
      phase_reg  <= phase_next;
      frame_tick <= (state_next == COMMIT);
      wr_ready   <= (state_next != COMMIT);
      if (state_next == SHOW && lit_next) begin
        ds_en  <= digit_enable(digit_next);
        ds_seg <= dec_seg;
        ds_dp  <= dec_dp;
      end else begin
        ds_en  <= EN_OFF;
        ds_seg <= NUM_BLK;
        ds_dp  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with DWELL_CYC = 8, GUARD_CYC = 2.
// A frame-position model (cycle index within a 41-cycle frame) predicts every
// output cycle by cycle; scenario tasks add spot checks from the decode table.
module tb_seg7_scan_ctrl;

  localparam int DW    = 8;
  localparam int GD    = 2;
  localparam int SLOT  = DW + GD;
  localparam int FRAME = 4 * SLOT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_digit = 2'd0;
  logic [3:0] wr_value = 4'd0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b1;
  logic       wr_ready;
  logic [6:0] ds_seg;
  logic       ds_dp;
  logic [3:0] ds_en;
  logic       frame_tick;
`ifdef SEG7_SCAN_BRIGHT_EN
  logic [2:0] bright = 3'd7;
`endif

  seg7_scan_ctrl #(.DWELL_CYC(DW), .GUARD_CYC(GD)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SEG7_SCAN_BRIGHT_EN
    .bright     (bright),
`endif
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digit   (wr_digit),
    .wr_value   (wr_value),
    .wr_dp      (wr_dp),
    .wr_blank   (wr_blank),
    .ds_seg     (ds_seg),
    .ds_dp      (ds_dp),
    .ds_en      (ds_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] v; logic dp; logic bl;} ent_t;
  typedef struct {int d; int v; bit dp; bit bl;} wr_t;

  ent_t       sh_m [4];
  ent_t       ac_m [4];
  logic [6:0] seg_tbl [16];
  wr_t        wq [$];
  int         n, thresh_m, checks, errors;
  logic [3:0] exp_en;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_tick, exp_ready;

  function automatic int cur_bright();
`ifdef SEG7_SCAN_BRIGHT_EN
    return int'(bright);
`else
    return 7;
`endif
  endfunction

  function automatic int cur_pos();
    return (n - 1) % FRAME;
  endfunction

  // Expected outputs for cycle n from its position inside the frame
  task automatic model_outputs();
    int pos, k, d, w;
    pos = cur_pos();
    exp_en = 4'hF; exp_seg = 7'h00; exp_dp = 1'b0; exp_tick = 1'b0; exp_ready = 1'b1;
    if (pos == 0) begin
      exp_tick = 1'b1; exp_ready = 1'b0;
    end else begin
      k = pos - 1; d = k / SLOT; w = k % SLOT;
      if (w < DW && w < thresh_m) begin
        exp_en = 4'hF ^ 4'(1 << d);
        if (!ac_m[d].bl) begin
          exp_seg = seg_tbl[ac_m[d].v];
          exp_dp  = ac_m[d].dp;
        end
      end
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      sh_m[i] = '{v: 4'h0, dp: 1'b0, bl: 1'b1};
      ac_m[i] = '{v: 4'h0, dp: 1'b0, bl: 1'b1};
    end
    wq.delete();
    wr_valid = 1'b0;
    n = 0; thresh_m = DW;
    exp_en = 4'hF; exp_seg = 7'h00; exp_dp = 1'b0; exp_tick = 1'b0; exp_ready = 1'b0;
  endtask

  // Drive the current cycle's write from the queue, advance one clock, update model
  task automatic tick();
    logic acc;
    if (wq.size() > 0) begin
      wr_valid = 1'b1; wr_digit = 2'(wq[0].d); wr_value = 4'(wq[0].v);
      wr_dp = wq[0].dp; wr_blank = wq[0].bl;
    end else begin
      wr_valid = 1'b0;
    end
    acc = wr_valid && exp_ready;
    if (acc) sh_m[wr_digit] = {wr_value, wr_dp, wr_blank};
    if (exp_tick) begin
      ac_m = sh_m;
      thresh_m = ((cur_bright() + 1) * DW) >> 3;
    end
    @(posedge clk); #1;
    if (acc) void'(wq.pop_front());
    n++;
    model_outputs();
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < FRAME && cur_pos() != p; i++) tick();
  endtask

  task automatic push_wr(input int d, input int v, input bit dp, input bit bl);
    wr_t w;
    w.d = d; w.v = v; w.dp = dp; w.bl = bl;
    wq.push_back(w);
  endtask

  task automatic test_reset();
    int lit_seg;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {4'hF, 7'h00, 3'b000}) begin
      errors++; $display("FAIL reset_values got %h expected %h", {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {4'hF, 7'h00, 3'b000});
    end
    @(negedge clk); rst = 1'b0;
    reset_model();
    lit_seg = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
        errors++; $display("FAIL reset_frame n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
      end
      if (i == 0) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++; $display("FAIL first_tick got %b expected 1", frame_tick);
        end
      end
      if (ds_seg != 7'h00) lit_seg++;
    end
    checks++;
    if (lit_seg != 0) begin
      errors++; $display("FAIL blank_frame lit cycles got %0d expected 0", lit_seg);
    end
  endtask

  task automatic test_write_display();
    int h0, h2;
    goto_pos(5);
    push_wr(0, 3, 1'b0, 1'b0);
    push_wr(2, 10, 1'b1, 1'b0);
    goto_pos(0);
    h0 = 0; h2 = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      tick();
      checks++;
      if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
        errors++; $display("FAIL write_display n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
      end
      if (ds_en == 4'b1110 && ds_seg == 7'h4F && !ds_dp) h0++;
      if (ds_en == 4'b1011 && ds_seg == 7'h77 && ds_dp) h2++;
    end
    checks++;
    if (h0 != DW) begin errors++; $display("FAIL digit0_4F cycles got %0d expected %0d", h0, DW); end
    checks++;
    if (h2 != DW) begin errors++; $display("FAIL digit2_77dp cycles got %0d expected %0d", h2, DW); end
  endtask

  task automatic test_last_write_wins();
    int h7f, h6d;
    goto_pos(5);
    push_wr(1, 5, 1'b0, 1'b0);
    push_wr(1, 8, 1'b0, 1'b0);
    goto_pos(0);
    h7f = 0; h6d = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      tick();
      checks++;
      if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
        errors++; $display("FAIL last_write n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
      end
      if (ds_en == 4'b1101 && ds_seg == 7'h7F) h7f++;
      if (ds_seg == 7'h6D) h6d++;
    end
    checks++;
    if (h7f != DW) begin errors++; $display("FAIL digit1_7F cycles got %0d expected %0d", h7f, DW); end
    checks++;
    if (h6d != 0) begin errors++; $display("FAIL stale_6D cycles got %0d expected 0", h6d); end
  endtask

  task automatic test_hold_across_commit();
    int early, late;
    goto_pos(0);
    checks++;
    if (wr_ready !== 1'b0 || frame_tick !== 1'b1) begin
      errors++; $display("FAIL commit_ready got rdy=%b tick=%b expected rdy=0 tick=1", wr_ready, frame_tick);
    end
    push_wr(3, 14, 1'b0, 1'b0);
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL post_commit_ready got %b expected 1", wr_ready);
    end
    early = 0; late = 0;
    for (int i = 0; i < 2 * FRAME - 1; i++) begin
      tick();
      checks++;
      if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
        errors++; $display("FAIL hold_commit n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
      end
      if (ds_en == 4'b0111 && ds_seg == 7'h79) begin
        if (i < FRAME - 2) early++; else late++;
      end
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL held_write_early cycles got %0d expected 0", early); end
    checks++;
    if (late != DW) begin errors++; $display("FAIL held_write_shown cycles got %0d expected %0d", late, DW); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (wq.size() == 0 && $urandom_range(3) == 0)
        push_wr(int'($urandom_range(3)), int'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(3) == 0));
      tick();
      checks++;
      if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
        errors++; $display("FAIL random n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
      end
    end
    while (wq.size() > 0 && n < 100 * FRAME) tick();
  endtask

`ifdef SEG7_SCAN_BRIGHT_EN
  task automatic test_bright();
    int on;
    for (int b = 0; b < 2; b++) begin
      bright = (b == 0) ? 3'd3 : 3'd7;
      goto_pos(0);
      on = 0;
      for (int i = 0; i < FRAME - 1; i++) begin
        tick();
        checks++;
        if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
          errors++; $display("FAIL bright n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
        end
        if (ds_en != 4'hF) on++;
      end
      checks++;
      if (on != ((b == 0) ? 16 : 32)) begin
        errors++; $display("FAIL bright_on bright=%0d got %0d expected %0d", bright, on, (b == 0) ? 16 : 32);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int lit;
    goto_pos(2);
    push_wr(0, 7, 1'b1, 1'b0);
    tick();
    checks++;
    if (ds_en !== 4'b1110) begin
      errors++; $display("FAIL pre_reset_en got %b expected 1110", ds_en);
    end
    wq.delete(); wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {4'hF, 7'h00, 3'b000}) begin
      errors++; $display("FAIL async_reset got %h expected %h", {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {4'hF, 7'h00, 3'b000});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    reset_model();
    lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({ds_en, ds_seg, ds_dp, frame_tick, wr_ready} !== {exp_en, exp_seg, exp_dp, exp_tick, exp_ready}) begin
        errors++; $display("FAIL after_reset n=%0d got %h expected %h", n, {ds_en, ds_seg, ds_dp, frame_tick, wr_ready}, {exp_en, exp_seg, exp_dp, exp_tick, exp_ready});
      end
      if (ds_seg != 7'h00 || ds_dp) lit++;
    end
    checks++;
    if (lit != 0) begin errors++; $display("FAIL reset_clears_digits lit cycles got %0d expected 0", lit); end
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};
    checks = 0; errors = 0;
    reset_model();
    test_reset();
    test_write_display();
    test_last_write_wins();
    test_hold_across_commit();
    test_random();
`ifdef SEG7_SCAN_BRIGHT_EN
    test_bright();
`endif
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
